fft_frame_sequencer: RTL and testbench

// Sequences the fft core between the i2s receiver and downstream spectrum logic: collects

---
 rtl/fft_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Collects i2s samples into ping-pong N-sample frames, streams each full frame into the fft,
// pulses start, then forwards the N result bins with their index.
module fft_frame_sequencer #(
  parameter int WIDTH = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               smp_valid,
  input  logic [23:0]        smp_data,
  output logic               fft_load,
  output logic [WIDTH-1:0]   fft_rd,
  output logic               fft_start,
  input  logic [2*WIDTH-1:0] fft_wd,
  input  logic               fft_done,
  output logic               bin_valid,
  output logic [N_2-1:0]     bin_idx,
  output logic [WIDTH-1:0]   bin_re,
  output logic [WIDTH-1:0]   bin_im,
  output logic               frame_done,
  output logic               overrun
);
  localparam int N = 1 << N_2;
  localparam logic [N_2-1:0] LAST = N_2'(N - 1);

  // IDLE wait for full bank | LOAD stream bank | START pulse, free bank | WAIT first bin | DRAIN bins
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2*N];
  logic [WIDTH-1:0] mem_d [2*N];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [N_2-1:0]   wptr_q, wptr_d;
  logic [N_2-1:0]   rptr_q, rptr_d;
  logic [N_2-1:0]   cnt_q, cnt_d;
  logic             bin_valid_q, bin_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic [N_2-1:0]   bin_idx_q, bin_idx_d;
  logic [WIDTH-1:0] bin_re_q, bin_re_d;
  logic [WIDTH-1:0] bin_im_q, bin_im_d;
  logic             wr_en;
  logic             wr_wrap;
  logic             release_bank;
  logic [WIDTH-1:0] smp_top;
  logic             smp_unused;

  assign smp_top      = smp_data[23 -: WIDTH];
  assign smp_unused   = ^smp_data[23-WIDTH:0];
  assign release_bank = (state_q == START);

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    overrun_d = overrun_q;
    wr_en     = smp_valid && !full_q[wr_bank_q];
    wr_wrap   = wr_en && (wptr_q == LAST);
    if (smp_valid && full_q[wr_bank_q]) begin
      overrun_d = 1'b1;
    end
    if (wr_en) begin
      mem_d[{wr_bank_q, wptr_q}] = smp_top;
      wptr_d = wptr_q + 1'b1;
    end
    // release first so a same-cycle wrap into the freed bank leaves it marked full
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d = ~wr_bank_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    rptr_d       = rptr_q;
    rd_bank_d    = rd_bank_q;
    cnt_d        = cnt_q;
    bin_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    bin_idx_d    = bin_idx_q;
    bin_re_d     = bin_re_q;
    bin_im_d     = bin_im_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = LOAD;
          rptr_d  = '0;
        end
      end
      LOAD: begin
        rptr_d = rptr_q + 1'b1;
        if (rptr_q == LAST) begin
          state_d = START;
        end
      end
      START: begin
        rd_bank_d = ~rd_bank_q;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT, DRAIN: begin
        if (fft_done) begin
          bin_valid_d  = 1'b1;
          bin_idx_d    = cnt_q;
          bin_re_d     = fft_wd[2*WIDTH-1:WIDTH];
          bin_im_d     = fft_wd[WIDTH-1:0];
          cnt_d        = cnt_q + 1'b1;
          frame_done_d = (cnt_q == LAST);
          state_d      = (cnt_q == LAST) ? IDLE : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      bin_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      bin_idx_q    <= '0;
      bin_re_q     <= '0;
      bin_im_q     <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      bin_valid_q  <= bin_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      bin_idx_q    <= bin_idx_d;
      bin_re_q     <= bin_re_d;
      bin_im_q     <= bin_im_d;
    end
  end

  // sample storage carries no reset: stale contents are never read before a refill
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fft_load   = (state_q == LOAD);
  assign fft_rd     = fft_load ? mem_q[{rd_bank_q, rptr_q}] : '0;
  assign fft_start  = (state_q == START);
  assign bin_valid  = bin_valid_q;
  assign bin_idx    = bin_idx_q;
  assign bin_re     = bin_re_q;
  assign bin_im     = bin_im_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer: a frame-queue model of capture and fft hand-off
// is checked against the DUT every cycle, plus literal expectations for directed scenarios.
module tb_fft_frame_sequencer;
  localparam int W  = 16;
  localparam int N2 = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          smp_valid;
  logic [23:0]   smp_data;
  logic          fft_load;
  logic [W-1:0]  fft_rd;
  logic          fft_start;
  logic [2*W-1:0] fft_wd;
  logic          fft_done;
  logic          bin_valid;
  logic [N2-1:0] bin_idx;
  logic [W-1:0]  bin_re;
  logic [W-1:0]  bin_im;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.WIDTH(W), .N_2(N2)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .fft_load(fft_load), .fft_rd(fft_rd), .fft_start(fft_start),
    .fft_wd(fft_wd), .fft_done(fft_done),
    .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im),
    .frame_done(frame_done), .overrun(overrun)
  );

  int n_chk = 0;
  int n_pass = 0;

  // model: captured frames waiting for the fft, plus the frame being filled
  typedef logic [W-1:0] frame_t [N];
  frame_t pend[$];
  frame_t part;
  int part_len = 0;
  int run = 0;
  int exp_bins = 0;
  int idle_cnt = 0;
  logic m_bv = 0, m_fd = 0, m_ovr = 0;
  logic [N2-1:0] m_idx = '0;
  logic [W-1:0] m_re = '0, m_im = '0;

  // stand-in fft behaviour
  int drv_rem = 0, drv_lat = 0, lat_cfg = 0, done_pct = 100;
  bit stray_en = 0;

  // observation log
  logic [W-1:0] load_log[$];
  int starts_seen = 0, bins_seen = 0, frames_seen = 0, smp_sent = 0;
  logic ovr_at64 = 1'b1, ovr_at65 = 1'b0;
  bit track_first = 0, first_seen = 0;
  logic [N2-1:0] first_idx = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input bit sv, input logic [23:0] d, input bit rn);
    int run_n;
    @(negedge clk);
    chk("bin_valid", bin_valid, m_bv);
    chk("frame_done", frame_done, m_fd);
    chk("overrun", overrun, m_ovr);
    chk("bin_idx", bin_idx, m_idx);
    chk("bin_re", bin_re, m_re);
    chk("bin_im", bin_im, m_im);
    if (fft_load) begin
      chk("load_len_ok", (run < N) && (pend.size() > 0), 1);
      if (run < N && pend.size() > 0) chk("fft_rd", fft_rd, pend[0][run]);
      chk("start_during_load", fft_start, 0);
      load_log.push_back(fft_rd);
      run_n = run + 1;
    end else begin
      chk("fft_rd_idle", fft_rd, 0);
      if (run > 0) chk("load_run_len", run, N);
      chk("fft_start", fft_start, run == N);
      run_n = 0;
    end
    if (pend.size() > 0 && exp_bins == 0 && !fft_load && !fft_start) idle_cnt++;
    else idle_cnt = 0;
    if (idle_cnt > 0) chk("idle_to_load", idle_cnt <= 1, 1);
    if (fft_start) starts_seen++;
    if (bin_valid) bins_seen++;
    if (frame_done) frames_seen++;
    if (track_first && bin_valid && !first_seen) begin
      first_seen = 1;
      first_idx = bin_idx;
    end
    if (smp_sent == 64) ovr_at64 = overrun;
    if (smp_sent == 65) ovr_at65 = overrun;

    // drive inputs for the coming edge
    reset = rn;
    smp_valid = sv;
    smp_data = d;
    fft_done = 1'b0;
    fft_wd = $urandom;
    if (drv_rem > 0) begin
      if (drv_lat > 0) drv_lat--;
      else if ($urandom_range(99) < done_pct) begin
        fft_done = 1'b1;
        drv_rem--;
      end
    end else if (stray_en && $urandom_range(9) == 0) begin
      fft_done = 1'b1;
    end
    if (fft_start) begin
      drv_rem = N;
      drv_lat = lat_cfg;
    end

    // model update for that edge
    if (!rn) begin
      drv_rem = 0;
      pend.delete();
      part_len = 0;
      run = 0;
      exp_bins = 0;
      idle_cnt = 0;
      m_bv = 0; m_fd = 0; m_ovr = 0; m_idx = '0; m_re = '0; m_im = '0;
    end else begin
      if (fft_done && exp_bins > 0) begin
        m_bv = 1;
        m_re = fft_wd[2*W-1:W];
        m_im = fft_wd[W-1:0];
        m_idx = N2'(N - exp_bins);
        m_fd = (exp_bins == 1);
        exp_bins--;
      end else begin
        m_bv = 0;
        m_fd = 0;
      end
      if (sv) begin
        smp_sent++;
        if (pend.size() == 2) m_ovr = 1;
        else begin
          part[part_len] = d[23 -: W];
          part_len++;
          if (part_len == N) begin
            pend.push_back(part);
            part_len = 0;
          end
        end
      end
      if (fft_start) begin
        if (pend.size() > 0) pend.delete(0);
        exp_bins = N;
      end
      run = run_n;
    end
  endtask

  task automatic wait_frames(input int target, input int limit, input string name);
    int i = 0;
    while (i < limit && frames_seen < target) begin
      tick(0, 24'h0, 1);
      i++;
    end
    chk(name, i < limit, 1);
  endtask

  initial begin
    int l0, s0, b0, f0, bad;
    reset = 0; smp_valid = 0; smp_data = 0; fft_done = 0; fft_wd = 0;
    repeat (2) @(negedge clk);

    // reset held with sample strobes toggling
    for (int i = 0; i < 5; i++) tick(i[0], 24'($urandom), 0);
    tick(0, 24'h0, 1);
    chk("reset_fft_load", fft_load, 0);
    chk("reset_bin_valid", bin_valid, 0);
    chk("reset_loads", load_log.size(), 0);

    // single frame, fft echoing done immediately
    done_pct = 100; lat_cfg = 0; stray_en = 0;
    l0 = load_log.size(); s0 = starts_seen; b0 = bins_seen; f0 = frames_seen;
    for (int k = 0; k < N; k++) tick(1, 24'(k * 256), 1);
    wait_frames(f0 + 1, 300, "single_timeout");
    chk("single_loads", load_log.size() - l0, 32);
    bad = 0;
    for (int k = 0; k < N; k++) if (load_log[l0 + k] !== 16'(k)) bad++;
    chk("single_rd_order", bad, 0);
    chk("single_starts", starts_seen - s0, 1);
    chk("single_bins", bins_seen - b0, 32);
    chk("single_last_idx", bin_idx, 31);

    // continuous: one sample per 4 cycles, slow fft
    lat_cfg = 200;
    b0 = bins_seen; f0 = frames_seen;
    for (int i = 0; i < 96; i++) begin
      tick(1, 24'($urandom), 1);
      repeat (3) tick(0, 24'h0, 1);
    end
    wait_frames(f0 + 3, 3000, "cont_timeout");
    chk("cont_frames", frames_seen - f0, 3);
    chk("cont_bins", bins_seen - b0, 96);
    chk("cont_overrun", overrun, 0);

    // randomized rates, latencies, gaps and stray done strobes
    stray_en = 1;
    for (int r = 0; r < 4; r++) begin
      int sp;
      done_pct = $urandom_range(20, 100);
      lat_cfg = $urandom_range(0, 40);
      sp = $urandom_range(20, 100);
      for (int i = 0; i < 250; i++) tick($urandom_range(99) < sp, 24'($urandom), 1);
    end
    done_pct = 100;
    begin
      int i = 0;
      while (i < 3000 && !(pend.size() == 0 && exp_bins == 0)) begin
        tick(0, 24'h0, 1);
        i++;
      end
      chk("rand_drain_timeout", i < 3000, 1);
    end
    stray_en = 0;

    // overrun with the fft stalled
    tick(0, 24'h0, 0); tick(0, 24'h0, 0);
    done_pct = 0; lat_cfg = 0; smp_sent = 0;
    b0 = bins_seen; f0 = frames_seen;
    for (int i = 0; i < 70; i++) tick(1, 24'($urandom), 1);
    repeat (5) tick(0, 24'h0, 1);
    chk("ovr_after_64", ovr_at64, 0);
    chk("ovr_after_65", ovr_at65, 1);
    chk("ovr_no_bins_while_stalled", bins_seen - b0, 0);
    done_pct = 100;
    wait_frames(f0 + 2, 1000, "ovr_timeout");
    chk("ovr_frames", frames_seen - f0, 2);
    chk("ovr_bins", bins_seen - b0, 64);
    chk("ovr_sticky", overrun, 1);

    // reset in the middle of a drain
    tick(0, 24'h0, 0); tick(0, 24'h0, 0);
    smp_sent = 0; lat_cfg = 5;
    b0 = bins_seen;
    for (int i = 0; i < N; i++) tick(1, 24'($urandom), 1);
    begin
      int i = 0;
      while (i < 500 && bins_seen - b0 < 10) begin
        tick(0, 24'h0, 1);
        i++;
      end
      chk("mid_timeout", i < 500, 1);
    end
    tick(0, 24'h0, 0);
    tick(0, 24'h0, 1);
    chk("mid_rst_bin_valid", bin_valid, 0);
    chk("mid_rst_bin_idx", bin_idx, 0);
    chk("mid_rst_fft_load", fft_load, 0);
    chk("mid_rst_overrun", overrun, 0);
    track_first = 1;
    b0 = bins_seen; f0 = frames_seen;
    for (int i = 0; i < N; i++) tick(1, 24'($urandom), 1);
    wait_frames(f0 + 1, 500, "mid_frame_timeout");
    chk("mid_first_idx", first_idx, 0);
    chk("mid_frames", frames_seen - f0, 1);
    chk("mid_bins", bins_seen - b0, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
